rsa_sequencer: RTL and testbench
================================

RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 1023: maximum number of RUN cycles allowed before abort; TIMEOUT >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream operand word valid.
REQ-006 in_ready  output  1  sequencer accepts a word this cycle.
REQ-007 in_data  input  WIDTH  operand word; fixed load order M, E, P, Const.
REQ-008 rsa_en  output  1  enable to the modular-exponentiation unit.
REQ-009 rsa_M, rsa_E, rsa_P, rsa_Const  output  WIDTH each  registered operands to the exponentiation unit.
REQ-010 rsa_C  input  WIDTH  result from the exponentiation unit.
REQ-011 rsa_eoc  input  1  end-of-computation from the exponentiation unit.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  WIDTH  captured result.
REQ-015 out_err  output  1  result is invalid (even modulus or timeout); qualified by out_valid.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, LOAD, CHECK, RUN, DONE; 2-bit word index widx; timeout counter tcnt of width ceil(log2(TIMEOUT+1)).
REQ-018 in_ready is 1 exactly in IDLE and LOAD; a word transfers when in_valid and in_ready are both high.
REQ-019 IDLE: a transfer stores the word in rsa_M, sets widx=1, and moves to LOAD.
REQ-020 LOAD: a transfer stores the word in rsa_E (widx 1), rsa_P (widx 2) or rsa_Const (widx 3), then increments widx; the transfer at widx 3 moves to CHECK and wraps widx to 0.
REQ-021 LOAD with in_valid low holds all state with no timeout; gaps between words are unlimited.
REQ-022 CHECK (one cycle): if rsa_M[0]==0, set out_data=0 and out_err=1 and go to DONE without asserting rsa_en; otherwise clear tcnt and go to RUN.
REQ-023 rsa_en is registered and is 1 exactly while in RUN; it rises on the first RUN cycle and falls on the cycle after leaving RUN.
REQ-024 RUN: rsa_eoc sampled high captures rsa_C into out_data, clears out_err, and moves to DONE.
REQ-025 RUN: otherwise tcnt increments; when tcnt reaches TIMEOUT, set out_data=0 and out_err=1 and go to DONE.
REQ-026 If rsa_eoc is high in the same cycle tcnt reaches TIMEOUT, eoc wins: the result is captured and out_err=0.
REQ-027 rsa_eoc is ignored in every state other than RUN.
REQ-028 DONE: out_valid=1, and out_data and out_err are held stable until out_valid and out_ready are both high; that handshake moves to IDLE and clears out_valid on the next cycle.
REQ-029 No new operand is accepted in CHECK, RUN or DONE; a minimum of one IDLE cycle separates consecutive jobs' DONE and LOAD.
REQ-030 Operand registers hold their values from load until overwritten by the next job.
REQ-031 Latency from the 4th word transfer to the first RUN cycle is 2 clk cycles; from rsa_eoc sampled high to out_valid=1 is 1 cycle.

Reset
REQ-032 rst high at a clock edge forces IDLE with widx=0, tcnt=0, in_ready=1, rsa_en=0, out_valid=0, out_err=0, out_data=0, rsa_M=rsa_E=rsa_P=rsa_Const=0, busy=0.
REQ-033 Reset in any state, including mid-LOAD and mid-RUN, aborts the job: partially loaded words are discarded and rsa_en falls on the next cycle.
REQ-034 While rst is high, in_valid is ignored and no transfer occurs.

Verification
REQ-035 The bench shall use a behavioural exponentiation stub that asserts rsa_eoc N cycles after rsa_en rises and drives rsa_C with a programmed value.
REQ-036 Nominal job: load M=0x0B, E=0x03, P=0x05, Const=0x04 with the stub set to N=20 and C=0x04 -> rsa_en high for 20 cycles, then out_valid=1, out_data=0x04, out_err=0, and the operand ports show the loaded values.
REQ-037 Even modulus: load M=0x0A -> CHECK goes straight to DONE, rsa_en never rises, out_data=0x00, out_err=1.
REQ-038 Timeout: with TIMEOUT=15 and a stub that never asserts rsa_eoc -> rsa_en stays high for exactly 15 cycles, then out_err=1, out_data=0.
REQ-039 Eoc at the timeout boundary: with TIMEOUT=15 and the stub N set so rsa_eoc is sampled on the cycle tcnt reaches 15 -> the result is captured and out_err=0.
REQ-040 Backpressure and gaps: insert random in_valid gaps during load and hold out_ready low for 10 cycles in DONE -> out_data is stable and exactly one result is delivered.
REQ-041 Reset mid-operation: assert rst after 2 of 4 words loaded, and separately in mid-RUN -> all outputs return to their reset values, and a fresh 4-word job then completes correctly.

Source files
------------

// File: rtl/rsa_sequencer_if.sv
// Stream handshake bundle for the RSA sequencer: operand words in, result word out.
interface rsa_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/rsa_sequencer.sv
// Loads M, E, P, Const over a valid/ready stream, runs the exponentiation unit with a
// timeout guard and returns one result word (or an error flag) per job.
module rsa_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  rsa_sequencer_if.slave   bus,
  output logic             rsa_en,
  output logic [WIDTH-1:0] rsa_M,
  output logic [WIDTH-1:0] rsa_E,
  output logic [WIDTH-1:0] rsa_P,
  output logic [WIDTH-1:0] rsa_Const,
  input  logic [WIDTH-1:0] rsa_C,
  input  logic             rsa_eoc,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [1:0]    widx;
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      widx          <= '0;
      tcnt          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_err   <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      rsa_en        <= 1'b0;
      rsa_M         <= '0;
      rsa_E         <= '0;
      rsa_P         <= '0;
      rsa_Const     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            rsa_M <= bus.in_data;
            widx  <= 2'd1;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (bus.in_valid) begin
            case (widx)
              2'd1:    rsa_E     <= bus.in_data;
              2'd2:    rsa_P     <= bus.in_data;
              default: rsa_Const <= bus.in_data;
            endcase
            // widx wraps to 0 after the Const word, ready for the next job
            widx <= widx + 2'd1;
            if (widx == 2'd3) begin
              bus.in_ready <= 1'b0;
              state        <= S_CHECK;
            end
          end
        end

        S_CHECK: begin
          // An even modulus is rejected without ever starting the unit
          if (!rsa_M[0]) begin
            bus.out_data  <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            tcnt   <= '0;
            rsa_en <= 1'b1;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          tcnt <= tcnt + 1'b1;
          // eoc takes priority over a timeout landing in the same cycle
          if (rsa_eoc) begin
            bus.out_data  <= rsa_C;
            bus.out_err   <= 1'b0;
            bus.out_valid <= 1'b1;
            rsa_en        <= 1'b0;
            state         <= S_DONE;
          end else if (tcnt == TLAST) begin
            bus.out_data  <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            rsa_en        <= 1'b0;
            state         <= S_DONE;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: begin
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          busy          <= 1'b0;
          rsa_en        <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_sequencer.sv
// Bench for rsa_sequencer: two instances (default timeout and TIMEOUT=15) share one
// operand stream; each has its own exponentiation stub and result monitor.
module tb_rsa_sequencer;
  localparam int W    = 8;
  localparam int TO_A = 1023;
  localparam int TO_B = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic         stray;
  int           stub_n;
  logic [W-1:0] stub_c;

  rsa_sequencer_if #(.WIDTH(W)) if_a ();
  rsa_sequencer_if #(.WIDTH(W)) if_b ();

  assign if_a.in_valid  = in_valid;
  assign if_a.in_data   = in_data;
  assign if_a.out_ready = out_ready;
  assign if_b.in_valid  = in_valid;
  assign if_b.in_data   = in_data;
  assign if_b.out_ready = out_ready;

  logic         a_en, b_en, a_eoc, b_eoc, a_busy, b_busy;
  logic [W-1:0] a_M, a_E, a_P, a_K, b_M, b_E, b_P, b_K;

  rsa_sequencer #(.WIDTH(W), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .bus(if_a), .rsa_en(a_en),
    .rsa_M(a_M), .rsa_E(a_E), .rsa_P(a_P), .rsa_Const(a_K),
    .rsa_C(stub_c), .rsa_eoc(a_eoc), .busy(a_busy)
  );

  rsa_sequencer #(.WIDTH(W), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .bus(if_b), .rsa_en(b_en),
    .rsa_M(b_M), .rsa_E(b_E), .rsa_P(b_P), .rsa_Const(b_K),
    .rsa_C(stub_c), .rsa_eoc(b_eoc), .busy(b_busy)
  );

  // Exponentiation stubs: eoc is raised in the stub_n-th cycle of rsa_en (never if 0)
  int a_scnt = 0, b_scnt = 0;
  always @(posedge clk) begin
    a_scnt <= a_en ? a_scnt + 1 : 0;
    b_scnt <= b_en ? b_scnt + 1 : 0;
  end
  assign a_eoc = stray || (a_en && stub_n != 0 && a_scnt == stub_n - 1);
  assign b_eoc = stray || (b_en && stub_n != 0 && b_scnt == stub_n - 1);

  // Monitors: cycle counter, enable-cycle totals, delivered results, enable rise time
  int           cyc = 0, a_entot = 0, b_entot = 0, a_dlv = 0, b_dlv = 0, a_rise = 0;
  logic [W-1:0] a_dd = '0, b_dd = '0;
  logic         a_de = 1'b0, b_de = 1'b0, a_en_q = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_en) a_entot <= a_entot + 1;
    if (b_en) b_entot <= b_entot + 1;
    if (if_a.out_valid && out_ready) begin
      a_dlv <= a_dlv + 1; a_dd <= if_a.out_data; a_de <= if_a.out_err;
    end
    if (if_b.out_valid && out_ready) begin
      b_dlv <= b_dlv + 1; b_dd <= if_b.out_data; b_de <= if_b.out_err;
    end
    if (a_en && !a_en_q) a_rise <= cyc;
    a_en_q <= a_en;
  end

  int checks = 0;
  int errors = 0;
  int xfer   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] m, e, p, k;
    int           n;
    logic [W-1:0] c;
    int           gap, hold;
    logic         stray;
    logic [W-1:0] xa_d;
    logic         xa_e;
    int           xa_en;
    logic [W-1:0] xb_d;
    logic         xb_e;
    int           xb_en;
  } vec_t;

  function automatic vec_t mk(input logic [W-1:0] m, e, p, k, input int n,
                              input logic [W-1:0] c, input int gap, hold, input logic s,
                              input logic [W-1:0] ad, input logic ae, input int aen,
                              input logic [W-1:0] bd, input logic be, input int ben);
    vec_t v;
    v.m = m; v.e = e; v.p = p; v.k = k; v.n = n; v.c = c; v.gap = gap; v.hold = hold;
    v.stray = s; v.xa_d = ad; v.xa_e = ae; v.xa_en = aen; v.xb_d = bd; v.xb_e = be;
    v.xb_en = ben;
    return v;
  endfunction

  // Job-level reference: even modulus fails, otherwise the result arrives if the
  // unit finishes within the timeout, else the job aborts after TIMEOUT enable cycles
  function automatic void model(input logic [W-1:0] m, input int n, input logic [W-1:0] c,
                                input int tmo, output logic [W-1:0] d, output logic e,
                                output int en);
    if (m[0] == 1'b0) begin
      d = '0; e = 1'b1; en = 0;
    end else if (n > 0 && n <= tmo) begin
      d = c; e = 1'b0; en = n;
    end else begin
      d = '0; e = 1'b1; en = tmo;
    end
  endfunction

  task automatic check_reset(input string name);
    chk({name, "_a"}, {if_a.in_ready, a_en, if_a.out_valid, if_a.out_err, if_a.out_data,
                       a_M, a_E, a_P, a_K, a_busy}, {1'b1, 44'd0});
    chk({name, "_b"}, {if_b.in_ready, b_en, if_b.out_valid, if_b.out_err, if_b.out_data,
                       b_M, b_E, b_P, b_K, b_busy}, {1'b1, 44'd0});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (if_a.in_ready && !a_busy && if_b.in_ready && !b_busy) break;
      @(negedge clk);
    end
    chk({tag, "_idle"}, {if_a.in_ready, a_busy, if_b.in_ready, b_busy}, 4'b1010);
  endtask

  task automatic send_words(input logic [W-1:0] m, e, p, k, input int gap);
    logic [W-1:0] w [4];
    w[0] = m; w[1] = e; w[2] = p; w[3] = k;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[i];
      xfer     = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int           sa, sb, da, db;
    logic [W-1:0] ha, hb;
    logic         hea, heb, stable;
    wait_idle(tag);
    stub_n = v.n; stub_c = v.c; stray = v.stray; out_ready = 1'b0;
    sa = a_entot; sb = b_entot; da = a_dlv; db = b_dlv;
    send_words(v.m, v.e, v.p, v.k, v.gap);
    for (int i = 0; i < 3000; i++) begin
      if (if_a.out_valid && if_b.out_valid) break;
      @(negedge clk);
    end
    chk({tag, "_valid"}, {if_a.out_valid, if_b.out_valid}, 2'b11);
    ha = if_a.out_data; hb = if_b.out_data; hea = if_a.out_err; heb = if_b.out_err;
    stable = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if ({if_a.out_valid, if_a.out_data, if_a.out_err} !== {1'b1, ha, hea} ||
          {if_b.out_valid, if_b.out_data, if_b.out_err} !== {1'b1, hb, heb}) stable = 1'b0;
    end
    if (v.hold > 0) chk({tag, "_hold"}, stable, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, {if_a.out_valid, if_b.out_valid}, 2'b00);
    chk({tag, "_res_a"}, {a_dd, a_de}, {v.xa_d, v.xa_e});
    chk({tag, "_res_b"}, {b_dd, b_de}, {v.xb_d, v.xb_e});
    chk({tag, "_encyc_a"}, a_entot - sa, v.xa_en);
    chk({tag, "_encyc_b"}, b_entot - sb, v.xb_en);
    chk({tag, "_dlv"}, {a_dlv - da, b_dlv - db}, {32'd1, 32'd1});
    chk({tag, "_ops_a"}, {a_M, a_E, a_P, a_K}, {v.m, v.e, v.p, v.k});
    chk({tag, "_ops_b"}, {b_M, b_E, b_P, b_K}, {v.m, v.e, v.p, v.k});
    if (v.m[0]) chk({tag, "_lat"}, a_rise - xfer, 2);
    stray = 1'b0;
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = mk(8'h0B, 8'h03, 8'h05, 8'h04, 20, 8'h04, 0, 0, 1'b0, 8'h04, 1'b0, 20, 8'h00, 1'b1, 15);
    tbl[1] = mk(8'h0A, 8'h03, 8'h05, 8'h04, 20, 8'h55, 0, 0, 1'b1, 8'h00, 1'b1, 0, 8'h00, 1'b1, 0);
    tbl[2] = mk(8'h0D, 8'h07, 8'h0B, 8'h01, 0, 8'hAA, 0, 0, 1'b0, 8'h00, 1'b1, 1023, 8'h00, 1'b1, 15);
    tbl[3] = mk(8'h0F, 8'h05, 8'h11, 8'h02, 15, 8'h3C, 1, 0, 1'b0, 8'h3C, 1'b0, 15, 8'h3C, 1'b0, 15);
    tbl[4] = mk(8'h0B, 8'h03, 8'h05, 8'h04, 16, 8'h77, 0, 0, 1'b0, 8'h77, 1'b0, 16, 8'h00, 1'b1, 15);
    tbl[5] = mk(8'hC5, 8'h13, 8'h29, 8'h6E, 1, 8'hFF, 0, 0, 1'b0, 8'hFF, 1'b0, 1, 8'hFF, 1'b0, 1);
    tbl[6] = mk(8'h09, 8'h03, 8'h21, 8'h07, 5, 8'h5A, 4, 10, 1'b0, 8'h5A, 1'b0, 5, 8'h5A, 1'b0, 5);

    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    stray = 1'b0; stub_n = 0; stub_c = '0;
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset("post_rst");

    for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.m = W'($urandom); v.e = W'($urandom); v.p = W'($urandom); v.k = W'($urandom);
      v.n = int'($urandom_range(25, 0)); v.c = W'($urandom);
      v.gap = int'($urandom_range(3, 0)); v.hold = int'($urandom_range(4, 0));
      v.stray = 1'b0;
      model(v.m, v.n, v.c, TO_A, v.xa_d, v.xa_e, v.xa_en);
      model(v.m, v.n, v.c, TO_B, v.xb_d, v.xb_e, v.xb_en);
      run_job(v, $sformatf("rnd%0d", i));
    end

    // Reset after two of four words: partial load is discarded
    wait_idle("rl");
    @(negedge clk); in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk); in_data = 8'h44;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_reset("rst_load");
    run_job(tbl[0], "fresh1");

    // Reset part-way through RUN
    wait_idle("rr");
    stub_n = 0; stub_c = 8'h99;
    send_words(8'h0F, 8'h01, 8'h02, 8'h03, 0);
    for (int i = 0; i < 50; i++) begin
      if (a_en) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("run_en", {a_en, b_en}, 2'b11);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_reset("rst_run");
    run_job(tbl[3], "fresh2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
